reg1_trace_fifo: RTL and testbench

- Downstream consumer of the MIPS system's Reg1_out result bus.
- Watches the 32-bit register value every cycle and captures each distinct new value into a small FIFO. Captured values are drained by a valid/ready consumer, such as a UART or bench scoreboard.
- Gives a lossless-or-flagged trace of program results, for example successive Fibonacci terms, without waveform inspection.

---
 rtl/reg1_trace_fifo_pkg.sv | 15 +
 rtl/reg1_trace_fifo_sync_fifo.sv | 55 +++++
 rtl/reg1_trace_fifo.sv | 76 +++++++
 tb/tb_reg1_trace_fifo.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/reg1_trace_fifo_pkg.sv
// trace_pkg: shared constants, log2 helper and change-detector state for the Reg1 trace FIFO.
package trace_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 16;
    localparam int CNT_W_DEF  = 16;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    typedef enum logic {UNPRIMED = 1'b0, PRIMED = 1'b1} det_state_e;
endpackage

// File: rtl/reg1_trace_fifo_sync_fifo.sv
// trace_sync_fifo: first-word fall-through FIFO with flush; a push into a full FIFO is
// accepted only when a pop frees the head slot in the same cycle.
module trace_sync_fifo
    import trace_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              wr_en, rd_en;

    assign full  = level_q == (ADDR_W+1)'(DEPTH);
    assign empty = level_q == '0;
    assign level = level_q;
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        rd_en    = pop & ~empty;
        wr_en    = push & (~full | rd_en);
        wr_ptr_d = flush ? '0 : wr_ptr_q + ADDR_W'(wr_en);
        rd_ptr_d = flush ? '0 : rd_ptr_q + ADDR_W'(rd_en);
        level_d  = flush ? '0 : level_q + (ADDR_W+1)'(wr_en) - (ADDR_W+1)'(rd_en);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage carries no reset; contents are only observable once level is non-zero.
    always_ff @(posedge clk) begin
        if (wr_en && !flush) mem_q[wr_ptr_q] <= wdata;
    end
endmodule

// File: rtl/reg1_trace_fifo.sv
// reg1_trace_fifo: captures each distinct new Reg1_out value into a FWFT FIFO,
// with sticky overflow and saturating capture/drop counters.
module reg1_trace_fifo
    import trace_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = clog2(DEPTH),
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [DATA_W-1:0] reg_in,
    input  logic              flush,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic [CNT_W-1:0]  capture_cnt,
    output logic [CNT_W-1:0]  drop_cnt
);
    det_state_e        state_q, state_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic              overflow_q, overflow_d;
    logic [CNT_W-1:0]  cap_q, cap_d, drop_q, drop_d;
    logic              capture, pop, drop, accept, full, empty;

    trace_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (capture),
        .pop   (out_ready),
        .flush (flush),
        .wdata (reg_in),
        .rdata (out_data),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign out_valid   = ~empty;
    assign overflow    = overflow_q;
    assign capture_cnt = cap_q;
    assign drop_cnt    = drop_q;

    // prev follows every capture, even one lost to a drop or a flush.
    always_comb begin
        capture    = en & ((state_q == UNPRIMED) | (reg_in != prev_q));
        pop        = out_valid & out_ready;
        drop       = capture & full & ~pop & ~flush;
        accept     = capture & ~drop & ~flush;
        state_d    = en ? PRIMED : state_q;
        prev_d     = capture ? reg_in : prev_q;
        overflow_d = ~flush & (overflow_q | drop);
        cap_d      = (accept && cap_q != '1) ? cap_q + CNT_W'(1) : cap_q;
        drop_d     = (drop && drop_q != '1) ? drop_q + CNT_W'(1) : drop_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= UNPRIMED;
            prev_q     <= '0;
            overflow_q <= 1'b0;
            cap_q      <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            overflow_q <= overflow_d;
            cap_q      <= cap_d;
            drop_q     <= drop_d;
        end
    end
endmodule

// File: tb/tb_reg1_trace_fifo.sv
// tb_reg1_trace_fifo: table-driven status checks plus a data scoreboard on every pop.
module tb_reg1_trace_fifo;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] reg_in = '0;
    logic [31:0] out_data;
    logic        out_valid;
    logic [4:0]  level;
    logic        overflow;
    logic [15:0] capture_cnt;
    logic [15:0] drop_cnt;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q [$];

    typedef struct {
        logic        en;
        logic [31:0] val;
        logic        rdy;
        logic        fl;
        logic        acc;
        logic [31:0] lvl;
        logic        vld;
        logic        ovf;
        logic [31:0] cap;
        logic [31:0] drp;
    } vec_t;

    reg1_trace_fifo dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .reg_in      (reg_in),
        .flush       (flush),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .level       (level),
        .overflow    (overflow),
        .capture_cnt (capture_cnt),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic st(input string tag, input logic [31:0] lvl, input logic vld, input logic ovf,
                      input logic [31:0] cap, input logic [31:0] drp);
        chk({tag, ".level"}, 32'(level), lvl);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(vld));
        chk({tag, ".overflow"}, 32'(overflow), 32'(ovf));
        chk({tag, ".capture_cnt"}, 32'(capture_cnt), cap);
        chk({tag, ".drop_cnt"}, 32'(drop_cnt), drp);
    endtask

    task automatic apply(input logic e, input logic [31:0] v, input logic r, input logic f, input logic a);
        en = e;
        reg_in = v;
        out_ready = r;
        flush = f;
        if (f) exp_q.delete();
        if (a) exp_q.push_back(v);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset && !flush && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL pop_data: got %0d, expected no pop", out_data);
            end else begin
                chk("pop_data", out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vec_t tbl [21];
        int   fib [7] = '{1, 1, 2, 3, 5, 8, 13};
        int   c;
        logic a;
        c = 1;
        for (int i = 0; i < 7; i++) begin
            a = 1'b1;
            if (i > 0) a = fib[i] != fib[i-1];
            if (a) c++;
            for (int j = 0; j < 3; j++)
                tbl[i*3+j] = '{1'b1, 32'(fib[i]), 1'b1, 1'b0, (j == 0) && a,
                               ((j == 0) && a) ? 32'd1 : 32'd0, (j == 0) && a, 1'b0, 32'(c), 32'd0};
        end

        repeat (2) @(posedge clk);
        #1;
        st("reset", 0, 0, 0, 0, 0);
        reset = 1'b0;

        for (int k = 0; k < 5; k++) apply(1, 32'(10 + k), 0, 0, 1);
        st("pre_reset", 5, 1, 0, 5, 0);
        #1 reset = 1'b1;
        #1;
        st("async_reset", 0, 0, 0, 0, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        apply(1, 0, 0, 0, 1);
        st("first_cap", 1, 1, 0, 1, 0);
        chk("first_cap.out_data", out_data, 0);

        for (int i = 0; i < 21; i++) begin
            apply(tbl[i].en, tbl[i].val, tbl[i].rdy, tbl[i].fl, tbl[i].acc);
            st($sformatf("fib[%0d]", i), tbl[i].lvl, tbl[i].vld, tbl[i].ovf, tbl[i].cap, tbl[i].drp);
        end

        for (int k = 0; k < 18; k++) apply(1, 32'(100 + k), 0, 0, k < 16);
        st("fill", 16, 1, 1, 23, 2);
        chk("fill.head", out_data, 100);
        for (int k = 0; k < 16; k++) begin
            apply(1, 117, 1, 0, 0);
            chk($sformatf("drain[%0d].level", k), 32'(level), 32'(15 - k));
        end
        st("drained", 0, 0, 1, 23, 2);

        for (int k = 0; k < 16; k++) apply(1, 32'(200 + k), 0, 0, 1);
        st("refill", 16, 1, 1, 39, 2);
        apply(1, 216, 1, 0, 1);
        st("full_pop", 16, 1, 1, 40, 2);
        chk("full_pop.head", out_data, 201);
        for (int k = 0; k < 16; k++) apply(0, 0, 1, 0, 0);
        st("drain2", 0, 0, 1, 40, 2);

        apply(1, 300, 1, 0, 1);
        st("empty_pp", 1, 1, 1, 41, 2);
        chk("empty_pp.out_data", out_data, 300);
        apply(1, 300, 1, 0, 0);
        chk("empty_pp2.level", 32'(level), 0);

        for (int k = 0; k < 7; k++) apply(1, 32'(400 + k), 0, 0, 1);
        st("pre_flush", 7, 1, 1, 48, 2);
        apply(1, 407, 1, 1, 0);
        st("flush", 0, 0, 0, 48, 2);
        apply(1, 407, 1, 0, 0);
        st("hold", 0, 0, 0, 48, 2);
        apply(1, 408, 0, 0, 1);
        st("post_flush", 1, 1, 0, 49, 2);
        chk("post_flush.out_data", out_data, 408);
        apply(0, 0, 1, 0, 0);
        chk("final.level", 32'(level), 0);
        chk("final.scoreboard", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
